// File: rtl/egress_drain_arbiter.sv
// Round-robin drain of four switch egress ports into one framed byte stream.
// A 2-entry skid buffer with a bypass path hides the switch's 1-cycle read latency.
module egress_drain_arbiter #(
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ready_0,
   input  logic              ready_1,
   input  logic              ready_2,
   input  logic              ready_3,
   input  logic [DATA_W-1:0] port0,
   input  logic [DATA_W-1:0] port1,
   input  logic [DATA_W-1:0] port2,
   input  logic [DATA_W-1:0] port3,
   output logic              read_0,
   output logic              read_1,
   output logic              read_2,
   output logic              read_3,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop,
   output logic              out_err,
   output logic [1:0]        out_port,
   output logic              busy
);

   // state | meaning
   // IDLE  | no grant; round-robin search over ready ports
   // HDR   | reading bytes 0..2; length not yet known
   // BODY  | reading payload and FCS until every byte is issued
   // DONE  | last byte in flight; drain one cycle
   // ABORT | source stalled too long; push an error eop byte when space exists

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int EW = DATA_W + 5;

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_BODY, S_DONE, S_ABORT} state_t;
   state_t state_q, state_d;

   logic [1:0]        ptr_q, gnt_q, arb_port, cand;
   logic              arb_hit;
   logic [3:0]        ready_v;
   logic              ready_g;
   logic [DATA_W-1:0] port_g;
   logic [8:0]        issued_q, rx_idx_q, total;
   logic [7:0]        len_q;
   logic              len_known_q, inflight_q;
   logic              owed, rd, rd_state, tmo_inc, tmo_hit, abort_push;
   logic [TW-1:0]     tmo_q;

   logic [EW-1:0]     mem_q [2];
   logic [EW-1:0]     src_ent, head;
   logic              rd_ptr_q, wr_ptr_q;
   logic [1:0]        count_q;
   logic              src_valid, src_sop, src_eop, src_err;
   logic [DATA_W-1:0] src_data;
   logic              buf_has, out_valid_i, pop, buf_pop, push;

   assign ready_v = {ready_3, ready_2, ready_1, ready_0};
   assign ready_g = ready_v[gnt_q];

   always_comb begin
      port_g = port0;
      case (gnt_q)
         2'd1:    port_g = port1;
         2'd2:    port_g = port2;
         2'd3:    port_g = port3;
         default: port_g = port0;
      endcase
   end

   always_comb begin
      arb_hit  = 1'b0;
      arb_port = ptr_q;
      cand     = ptr_q;
      for (int i = 1; i <= 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!arb_hit && ready_v[cand]) begin
            arb_hit  = 1'b1;
            arb_port = cand;
         end
      end
   end

   // Until byte 2 lands the packet could be as short as 4 bytes, so cap at 3 reads.
   assign total    = {1'b0, len_q} + 9'd4;
   assign owed     = len_known_q ? (issued_q < total) : (issued_q < 9'd3);
   assign rd_state = (state_q == S_HDR) || (state_q == S_BODY);
   assign rd       = rd_state && ready_g && ((count_q + {1'b0, inflight_q}) < 2'd2) && owed;

   assign read_0 = rd && (gnt_q == 2'd0);
   assign read_1 = rd && (gnt_q == 2'd1);
   assign read_2 = rd && (gnt_q == 2'd2);
   assign read_3 = rd && (gnt_q == 2'd3);

   assign tmo_inc    = rd_state && !ready_g && owed;
   assign tmo_hit    = tmo_inc && (tmo_q == TW'(TIMEOUT_CYC - 1));
   assign abort_push = (state_q == S_ABORT) && !inflight_q && (count_q != 2'd2);

   assign src_valid = inflight_q || abort_push;
   assign src_sop   = (rx_idx_q == 9'd0);
   assign src_eop   = abort_push || (len_known_q && (rx_idx_q == total - 9'd1));
   assign src_err   = abort_push;
   assign src_data  = abort_push ? '0 : port_g;
   assign src_ent   = {gnt_q, src_err, src_eop, src_sop, src_data};

   // An arriving byte bypasses the buffer only when it is empty.
   assign buf_has     = (count_q != 2'd0);
   assign out_valid_i = buf_has || src_valid;
   assign head        = buf_has ? mem_q[rd_ptr_q] : src_ent;
   assign pop         = out_valid_i && out_ready;
   assign buf_pop     = pop && buf_has;
   assign push        = src_valid && !(pop && !buf_has);

   assign out_valid = out_valid_i;
   assign {out_port, out_err, out_eop, out_sop, out_data} = out_valid_i ? head : '0;
   assign busy = (state_q != S_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (arb_hit) state_d = S_HDR;
         S_HDR: begin
            if (tmo_hit)                                state_d = S_ABORT;
            else if (inflight_q && rx_idx_q == 9'd2)    state_d = S_BODY;
         end
         S_BODY: begin
            if (tmo_hit)                                state_d = S_ABORT;
            else if (rd && (issued_q + 9'd1 == total))  state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         S_ABORT: if (abort_push) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q       <= 2'd3;
         gnt_q       <= 2'd0;
         issued_q    <= '0;
         rx_idx_q    <= '0;
         len_q       <= '0;
         len_known_q <= 1'b0;
         inflight_q  <= 1'b0;
         tmo_q       <= '0;
      end else begin
         inflight_q <= rd;
         if (state_q == S_IDLE && arb_hit) begin
            gnt_q       <= arb_port;
            ptr_q       <= arb_port;
            issued_q    <= '0;
            rx_idx_q    <= '0;
            len_q       <= '0;
            len_known_q <= 1'b0;
            tmo_q       <= '0;
         end else begin
            if (rd) issued_q <= issued_q + 9'd1;
            if (inflight_q) begin
               rx_idx_q <= rx_idx_q + 9'd1;
               if (rx_idx_q == 9'd2) begin
                  len_q       <= port_g[7:0];
                  len_known_q <= 1'b1;
               end
            end
            if (rd)           tmo_q <= '0;
            else if (tmo_inc) tmo_q <= tmo_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= src_ent;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (buf_pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, buf_pop};
      end
   end

endmodule

// File: tb/tb_egress_drain_arbiter.sv
// Directed bench: a queue-based switch model feeds the arbiter; accepted bytes are
// compared against packets built by the bench.
module tb_egress_drain_arbiter;
   localparam int DW = 8;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          out_ready = 1'b1;
   logic [3:0]    rdy = 4'b0;
   logic [3:0]    hold = 4'b0;
   logic [DW-1:0] pd [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
   wire  [3:0]    rd;
   wire  [DW-1:0] out_data;
   wire           out_valid, out_sop, out_eop, out_err, busy;
   wire  [1:0]    out_port;

   logic [7:0]    swq [4][$];
   logic [12:0]   got [$];
   logic [12:0]   exp_q [$];
   logic [3:0]    rd_prev = 4'b0;
   int            cyc = 0, ovl_err = 0, outstanding = 0, max_out = 0;
   int            reads_n [4] = '{0, 0, 0, 0};
   int            checks = 0, errors = 0;

   egress_drain_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset),
      .ready_0(rdy[0]), .ready_1(rdy[1]), .ready_2(rdy[2]), .ready_3(rdy[3]),
      .port0(pd[0]), .port1(pd[1]), .port2(pd[2]), .port3(pd[3]),
      .read_0(rd[0]), .read_1(rd[1]), .read_2(rd[2]), .read_3(rd[3]),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err),
      .out_port(out_port), .busy(busy)
   );

   always #5 clk = ~clk;

   // Switch model: a read seen in one cycle presents its byte in the next one.
   always @(negedge clk) begin
      cyc++;
      for (int n = 0; n < 4; n++) begin
         if (rd_prev[n]) pd[n] = (swq[n].size() > 0) ? swq[n].pop_front() : 8'hEE;
         rdy[n] = (swq[n].size() > 0) && !hold[n];
      end
      #2;
      rd_prev = rd;
      if (!$onehot0(rd)) ovl_err++;
      for (int n = 0; n < 4; n++) if (rd[n]) reads_n[n]++;
      if (out_valid && out_ready) got.push_back({out_port, out_err, out_eop, out_sop, out_data});
      outstanding += $countones(rd) - ((out_valid && out_ready) ? 1 : 0);
      if (outstanding > max_out) max_out = outstanding;
   end

   task automatic load_pkt(input int n, input int len, input logic [7:0] seed);
      logic [7:0] b;
      int tot;
      tot = len + 4;
      for (int i = 0; i < tot; i++) begin
         if (i == 0)            b = seed;
         else if (i == 1)       b = seed + 8'd1;
         else if (i == 2)       b = 8'(len);
         else if (i == tot - 1) b = seed ^ 8'hFF;
         else                   b = seed + 8'h10 + 8'(i - 3);
         swq[n].push_back(b);
         exp_q.push_back({2'(n), 1'b0, (i == tot - 1), (i == 0), b});
      end
   endtask

   task automatic clear_all();
      got.delete();
      exp_q.delete();
      for (int n = 0; n < 4; n++) reads_n[n] = 0;
      ovl_err = 0;
      outstanding = 0;
      max_out = 0;
   endtask

   task automatic wait_got(input int n, input int budget, output bit ok);
      int k;
      k = 0;
      while (got.size() < n && k < budget) begin
         @(negedge clk); #3;
         k++;
      end
      ok = (got.size() >= n);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({out_valid, out_sop, out_eop, out_err, out_port, out_data, rd, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b data=%h read=%b busy=%b, required all zero",
                  out_valid, out_data, rd, busy);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      checks++;
      if ({out_valid, rd, busy} !== '0) begin
         errors++;
         $display("FAIL idle_after_reset: valid=%b read=%b busy=%b, required 0", out_valid, rd, busy);
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      clear_all();
      load_pkt(0, 0, 8'h10);
      load_pkt(1, 0, 8'h20);
      load_pkt(2, 0, 8'h30);
      load_pkt(3, 0, 8'h40);
      load_pkt(0, 0, 8'h50);
      wait_got(20, 200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_timeout: got %0d bytes, required 20", got.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rr_byte%0d: got %h, required %h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (ovl_err !== 0) begin errors++; $display("FAIL rr_overlap: %0d overlapping cycles, required 0", ovl_err); end
      checks++;
      if (reads_n[0] !== 8 || reads_n[1] !== 4 || reads_n[2] !== 4 || reads_n[3] !== 4) begin
         errors++;
         $display("FAIL rr_reads: %0d/%0d/%0d/%0d, required 8/4/4/4", reads_n[0], reads_n[1], reads_n[2], reads_n[3]);
      end
   endtask

   task automatic test_single_port();
      bit ok;
      clear_all();
      load_pkt(0, 2, 8'hA0);
      wait_got(6, 100, ok);
      repeat (4) @(negedge clk);
      #3;
      checks++;
      if (got.size() !== 6) begin errors++; $display("FAIL single_count: got %0d bytes, required 6", got.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL single_byte%0d: got %h, required %h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (reads_n[0] !== 6 || (reads_n[1] + reads_n[2] + reads_n[3]) !== 0) begin
         errors++;
         $display("FAIL single_reads: read_0 %0d others %0d, required 6 and 0",
                  reads_n[0], reads_n[1] + reads_n[2] + reads_n[3]);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: busy=%b, required 0", busy); end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [12:0] snap;
      clear_all();
      load_pkt(0, 5, 8'h40);
      wait_got(4, 100, ok);
      @(negedge clk);
      out_ready = 1'b0;
      for (int s = 0; s < 10; s++) begin
         #3;
         if (s == 0) snap = {out_port, out_err, out_eop, out_sop, out_data};
         checks++;
         if (out_valid !== 1'b1 || {out_port, out_err, out_eop, out_sop, out_data} !== snap) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b out=%h, required 1 and %h", s, out_valid,
                     {out_port, out_err, out_eop, out_sop, out_data}, snap);
         end
         if (s >= 2) begin
            checks++;
            if (rd !== 4'b0) begin errors++; $display("FAIL bp_read%0d: read=%b, required 0000", s, rd); end
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      wait_got(9, 100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_timeout: got %0d bytes, required 9", got.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL bp_byte%0d: got %h, required %h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (max_out > 2) begin errors++; $display("FAIL bp_outstanding: peak %0d, required <= 2", max_out); end
   endtask

   task automatic test_timeout();
      int  c_drop, c_abort, k;
      bit  seen;
      clear_all();
      c_drop = -1; c_abort = -1; k = 0; seen = 1'b0;
      swq[1].push_back(8'hC0); exp_q.push_back({2'd1, 1'b0, 1'b0, 1'b1, 8'hC0});
      swq[1].push_back(8'hC1); exp_q.push_back({2'd1, 1'b0, 1'b0, 1'b0, 8'hC1});
      swq[1].push_back(8'h0A); exp_q.push_back({2'd1, 1'b0, 1'b0, 1'b0, 8'h0A});
      swq[1].push_back(8'hD0); exp_q.push_back({2'd1, 1'b0, 1'b0, 1'b0, 8'hD0});
      exp_q.push_back({2'd1, 1'b1, 1'b1, 1'b0, 8'h00});
      while (c_abort < 0 && k < 200) begin
         @(negedge clk); #3;
         k++;
         if (c_drop < 0 && seen && !rdy[1]) c_drop = cyc;
         if (rdy[1]) seen = 1'b1;
         if (out_valid && out_err) c_abort = cyc;
      end
      repeat (4) @(negedge clk);
      #3;
      checks++;
      if (c_abort < 0 || c_drop < 0 || (c_abort - c_drop) !== TO) begin
         errors++;
         $display("FAIL tmo_latency: abort %0d cycles after ready drop, required %0d", c_abort - c_drop, TO);
      end
      checks++;
      if (got.size() !== 5) begin errors++; $display("FAIL tmo_count: got %0d bytes, required 5", got.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL tmo_byte%0d: got %h, required %h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (busy !== 1'b0 || reads_n[1] !== 4) begin
         errors++;
         $display("FAIL tmo_idle: busy=%b reads=%0d, required 0 and 4", busy, reads_n[1]);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      clear_all();
      load_pkt(2, 5, 8'h60);
      wait_got(4, 100, ok);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_sop, out_eop, out_err, out_port, out_data, rd, busy} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: valid=%b data=%h read=%b busy=%b, required all zero",
                  out_valid, out_data, rd, busy);
      end
      repeat (2) @(negedge clk);
      #3;
      for (int n = 0; n < 4; n++) swq[n].delete();
      clear_all();
      @(negedge clk);
      reset = 1'b1;
      #3;
      load_pkt(0, 0, 8'h90);
      load_pkt(3, 0, 8'h80);
      wait_got(8, 100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL midreset_timeout: got %0d bytes, required 8", got.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL midreset_byte%0d: got %h, required %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_port();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
